// File: rtl/data_mem_responder.sv
// Memory-side responder for the core's data port: single-word reads/writes against a
// word-wide array with programmable wait states, a one-cycle data_ready pulse and
// error reporting for misaligned, out-of-range or conflicting requests.
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous active-low reset of all control state (array kept)
//   data_addr  - byte address of the access
//   data_out   - write data from the core
//   data_read  - read request
//   data_write - write request
//   data_in    - read data to the core, valid while data_ready=1
//   data_ready - one-cycle completion pulse
//   data_err   - access rejected, qualifies data_ready
module data_mem_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_out,
  input  logic        data_read,
  input  logic        data_write,
  output logic [31:0] data_in,
  output logic        data_ready,
  output logic        data_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = 4;
  localparam logic [31:0] SPAN = 32'(4 * DEPTH);
  localparam bit HAS_WAIT = (WAIT_STATES != 0);
  localparam logic [CW-1:0] CNT_INIT = HAS_WAIT ? CW'(WAIT_STATES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic          wr_q;
  logic          err_q;

  logic [31:0] mem [DEPTH];

  // Request decode, used at the accept edge
  logic [31:0] off_c;
  logic        req_c;
  logic        acc_err_c;
  logic        accept_c;
  logic        enter_resp_c;

  assign off_c     = data_addr - ADDR_BASE;
  assign req_c     = data_read | data_write;
  assign acc_err_c = (data_read & data_write) | (off_c[1:0] != 2'b00) | (off_c >= SPAN);
  assign accept_c  = (state_q == S_IDLE) && req_c;

  // With zero wait states the commit edge is the accept edge, so the live request is
  // used instead of the not-yet-latched copy.
  logic [AW-1:0] sel_idx_c;
  logic [31:0]   sel_wdata_c;
  logic          sel_wr_c;
  logic          sel_err_c;

  always_comb begin
    sel_idx_c   = idx_q;
    sel_wdata_c = wdata_q;
    sel_wr_c    = wr_q;
    sel_err_c   = err_q;
    if (state_q == S_IDLE) begin
      sel_idx_c   = off_c[AW+1:2];
      sel_wdata_c = data_out;
      sel_wr_c    = data_write;
      sel_err_c   = acc_err_c;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_c) begin
          if (HAS_WAIT) begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign enter_resp_c = (state_d == S_RESP);

  // Request latch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else if (accept_c) begin
      idx_q   <= off_c[AW+1:2];
      wdata_q <= data_out;
      wr_q    <= data_write;
      err_q   <= acc_err_c;
    end
  end

  // Array write; gated by reset so an aborted write never lands
  always_ff @(posedge clk) begin
    if (reset && enter_resp_c && sel_wr_c && !sel_err_c) begin
      mem[sel_idx_c] <= sel_wdata_c;
    end
  end

  // Registered response
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_in    <= '0;
      data_ready <= 1'b0;
      data_err   <= 1'b0;
    end else begin
      data_ready <= enter_resp_c;
      data_err   <= enter_resp_c & sel_err_c;
      if (enter_resp_c) begin
        if (sel_err_c) begin
          data_in <= '0;
        end else if (!sel_wr_c) begin
          data_in <= mem[sel_idx_c];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three instances cover WAIT_STATES=1, 0 and 3
// (the last one with a non-zero ADDR_BASE).
module tb_data_mem_responder;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr [3];
  logic [31:0] wdat [3];
  logic        rdq  [3];
  logic        wrq  [3];
  logic [31:0] din  [3];
  logic        rdy  [3];
  logic        err  [3];

  int checks = 0;
  int errors = 0;

  data_mem_responder #(.DEPTH(1024), .WAIT_STATES(1), .ADDR_BASE(32'h0000_0000)) u0 (
    .clk(clk), .reset(rst_n), .data_addr(addr[0]), .data_out(wdat[0]),
    .data_read(rdq[0]), .data_write(wrq[0]), .data_in(din[0]),
    .data_ready(rdy[0]), .data_err(err[0]));

  data_mem_responder #(.DEPTH(1024), .WAIT_STATES(0), .ADDR_BASE(32'h0000_0000)) u1 (
    .clk(clk), .reset(rst_n), .data_addr(addr[1]), .data_out(wdat[1]),
    .data_read(rdq[1]), .data_write(wrq[1]), .data_in(din[1]),
    .data_ready(rdy[1]), .data_err(err[1]));

  data_mem_responder #(.DEPTH(1024), .WAIT_STATES(3), .ADDR_BASE(32'h1000_0000)) u2 (
    .clk(clk), .reset(rst_n), .data_addr(addr[2]), .data_out(wdat[2]),
    .data_read(rdq[2]), .data_write(wrq[2]), .data_in(din[2]),
    .data_ready(rdy[2]), .data_err(err[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          u;
    bit          rd;
    bit          wr;
    logic [31:0] a;
    logic [31:0] wd;
    int          lat;
    bit          eerr;
    logic [31:0] edata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int u, input bit rd, input bit wr,
                              input logic [31:0] a, input logic [31:0] wd,
                              input int lat, input bit e, input logic [31:0] d);
    vec_t v;
    v.u = u; v.rd = rd; v.wr = wr; v.a = a; v.wd = wd;
    v.lat = lat; v.eerr = e; v.edata = d;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one access on instance u; returns with the instance in its response cycle
  // (or after a bounded wait), lat = cycles from accept cycle to data_ready cycle.
  task automatic access(input int u, input bit rd, input bit wr,
                        input logic [31:0] a, input logic [31:0] wd, output int lat);
    @(negedge clk);
    rdq[u] = rd; wrq[u] = wr; addr[u] = a; wdat[u] = wd;
    @(posedge clk); #1;
    rdq[u] = 1'b0; wrq[u] = 1'b0;
    lat = 1;
    while (!rdy[u] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int  lat;
    bit  prev;
    bit  seen;
    string nm;

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      addr[i] = '0; wdat[i] = '0; rdq[i] = 1'b0; wrq[i] = 1'b0;
    end

    // u0: WAIT_STATES=1, base 0
    vecs.push_back(mk(0, 0, 1, 32'h10,  32'hDEAD_BEEF, 2, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h10,  32'h0,         2, 0, 32'hDEAD_BEEF));
    vecs.push_back(mk(0, 1, 0, 32'h13,  32'h0,         2, 1, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h1000, 32'h0,        2, 1, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h10,  32'h0,         2, 0, 32'hDEAD_BEEF));
    vecs.push_back(mk(0, 0, 1, 32'h20,  32'hCAFE_F00D, 2, 0, 32'hDEAD_BEEF));
    vecs.push_back(mk(0, 1, 1, 32'h20,  32'h1234_5678, 2, 1, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h20,  32'h0,         2, 0, 32'hCAFE_F00D));
    vecs.push_back(mk(0, 0, 1, 32'hFFC, 32'h0BAD_F00D, 2, 0, 32'hCAFE_F00D));
    vecs.push_back(mk(0, 1, 0, 32'hFFC, 32'h0,         2, 0, 32'h0BAD_F00D));
    // u2: WAIT_STATES=3, base 0x1000_0000
    vecs.push_back(mk(2, 0, 1, 32'h1000_0FFC, 32'h7777_8888, 4, 0, 32'h0));
    vecs.push_back(mk(2, 1, 0, 32'h1000_0FFC, 32'h0,         4, 0, 32'h7777_8888));
    vecs.push_back(mk(2, 1, 0, 32'h0FFF_FFFC, 32'h0,         4, 1, 32'h0));
    vecs.push_back(mk(2, 0, 1, 32'h1000_0042, 32'h9999_9999, 4, 1, 32'h0));
    vecs.push_back(mk(2, 0, 1, 32'h1000_0040, 32'h1111_2222, 4, 0, 32'h0));
    vecs.push_back(mk(2, 1, 0, 32'h1000_0040, 32'h0,         4, 0, 32'h1111_2222));
    // u1: WAIT_STATES=0
    vecs.push_back(mk(1, 0, 1, 32'h0, 32'h5555_AAAA, 1, 0, 32'h0));
    vecs.push_back(mk(1, 1, 0, 32'h0, 32'h0,         1, 0, 32'h5555_AAAA));

    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_data_in[%0d]", i), din[i], 32'h0);
      chk($sformatf("reset_ready[%0d]", i), 32'(rdy[i]), 32'h0);
      chk($sformatf("reset_err[%0d]", i), 32'(err[i]), 32'h0);
    end
    rst_n = 1'b1;

    // Table-driven accesses
    foreach (vecs[i]) begin
      access(vecs[i].u, vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].wd, lat);
      nm = $sformatf("vec%0d_u%0d_%h", i, vecs[i].u, vecs[i].a);
      chk({nm, "_latency"}, 32'(lat), 32'(vecs[i].lat));
      chk({nm, "_err"}, 32'(err[vecs[i].u]), 32'(vecs[i].eerr));
      chk({nm, "_data"}, din[vecs[i].u], vecs[i].edata);
      @(posedge clk); #1;
      chk({nm, "_ready_drops"}, 32'(rdy[vecs[i].u]), 32'h0);
    end

    // WAIT_STATES=0 with request held: pulses every other cycle, never back to back
    @(negedge clk);
    rdq[1] = 1'b1; addr[1] = 32'h0;
    prev = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("held_ready_cyc%0d", k), 32'(rdy[1]), 32'((k % 2) == 0));
      if (prev && rdy[1]) chk($sformatf("held_no_consecutive_cyc%0d", k), 32'h1, 32'h0);
      if (rdy[1]) chk($sformatf("held_data_cyc%0d", k), din[1], 32'h5555_AAAA);
      prev = rdy[1];
      if (k == 3) rdq[1] = 1'b0;
    end
    @(posedge clk); #1;
    chk("held_ready_after_drop", 32'(rdy[1]), 32'h0);

    // Reset in the second WAIT cycle of a WAIT_STATES=3 write
    @(negedge clk);
    wrq[2] = 1'b1; addr[2] = 32'h1000_0040; wdat[2] = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    wrq[2] = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("abort_data_in_zero", din[2], 32'h0);
    chk("abort_ready_zero", 32'(rdy[2]), 32'h0);
    chk("abort_err_zero", 32'(err[2]), 32'h0);
    chk("abort_other_inst_data_in_zero", din[0], 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (rdy[2]) seen = 1'b1;
    end
    chk("abort_no_late_ready", 32'(seen), 32'h0);
    access(2, 1, 0, 32'h1000_0040, 32'h0, lat);
    chk("abort_reread_latency", 32'(lat), 32'd4);
    chk("abort_reread_err", 32'(err[2]), 32'h0);
    chk("abort_reread_data", din[2], 32'h1111_2222);

    // Array survives reset on the other instances too
    access(0, 1, 0, 32'h10, 32'h0, lat);
    chk("post_reset_u0_data", din[0], 32'hDEAD_BEEF);
    chk("post_reset_u0_latency", 32'(lat), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
